// File: rtl/qspi_dual_phy.sv
// Dual-line QSPI pad front end: synchronizes SS/SCLK/QD into CLK, assembles received
// 2-bit pairs into bytes and shifts transmit bytes onto QD under a ready/load handshake.
module qspi_dual_phy #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SS,
  input  logic       SCLK,
  input  logic [1:0] QD_READ,
  output logic [1:0] QD_WRITE,
  output logic [1:0] QD_WRITE_ENABLE,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_FIRST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_LOAD,
  output logic       TX_READY,
  input  logic       TX_EN,
  output logic       TX_UNDERRUN,
  output logic       BUSY,
  output logic       FRAME_START,
  output logic       FRAME_END,
  output logic       ERR_PARTIAL
);
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e                      state_q, state_d;
  logic [SYNC_STAGES-1:0]      ss_sync_q, sclk_sync_q;
  logic [SYNC_STAGES-1:0][1:0] qd_sync_q;
  logic                        ss_prev_q, sclk_prev_q;
  logic                        ss_fall_s, ss_rise_s, sclk_rise_s, sclk_fall_s;
  logic [1:0]                  qd_s;
  logic                        tx_take_s;

  logic [1:0] cnt_q, cnt_d;
  logic [5:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rxb_done_q, rxb_done_d, rxb_first_q, rxb_first_d;
  logic       rx_valid_q, rx_valid_d, rx_first_q, rx_first_d;
  logic       first_byte_q, first_byte_d;
  logic [7:0] tx_shift_q, tx_shift_d, hold_q, hold_d;
  logic       tx_ready_q, tx_ready_d, underrun_q, underrun_d;
  logic       load_pend_q, load_pend_d;
  logic       frame_start_q, frame_start_d, frame_end_q, frame_end_d;
  logic       err_partial_q, err_partial_d;
  logic [1:0] qd_write_q, qd_write_d, qd_oe_q, qd_oe_d;

  // Synchronizer chains; the extra prev flops feed the edge detectors.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ss_sync_q   <= '0;
      sclk_sync_q <= '0;
      qd_sync_q   <= '0;
      ss_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      qd_sync_q   <= {qd_sync_q[SYNC_STAGES-2:0], QD_READ};
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign ss_fall_s   = ss_prev_q & ~ss_sync_q[SYNC_STAGES-1];
  assign ss_rise_s   = ~ss_prev_q & ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = ~sclk_prev_q & sclk_sync_q[SYNC_STAGES-1];
  assign sclk_fall_s = sclk_prev_q & ~sclk_sync_q[SYNC_STAGES-1];
  assign qd_s        = qd_sync_q[SYNC_STAGES-1];

  // Frame state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, RX assembly, TX shift/holding handshake and registered pad drive.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rxb_done_d    = 1'b0;
    rxb_first_d   = 1'b0;
    rx_valid_d    = rxb_done_q;
    rx_first_d    = rxb_done_q & rxb_first_q;
    first_byte_d  = first_byte_q;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    tx_ready_d    = tx_ready_q;
    underrun_d    = underrun_q;
    load_pend_d   = load_pend_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    err_partial_d = 1'b0;
    qd_write_d    = tx_shift_q[7:6];
    qd_oe_d       = {2{TX_EN & (state_q == ACTIVE)}};
    tx_take_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall_s) begin
          state_d       = ACTIVE;
          frame_start_d = 1'b1;
          cnt_d         = 2'd0;
          underrun_d    = 1'b0;
          load_pend_d   = 1'b0;
          first_byte_d  = 1'b1;
          tx_take_s     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (sclk_rise_s) begin
          rx_shift_d = {rx_shift_q[3:0], qd_s};
          cnt_d      = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            rx_data_d    = {rx_shift_q, qd_s};
            rxb_done_d   = 1'b1;
            rxb_first_d  = first_byte_q;
            first_byte_d = 1'b0;
            load_pend_d  = 1'b1;
          end else begin
            load_pend_d = load_pend_q;
          end
        end else if (sclk_fall_s) begin
          if (load_pend_q) begin
            load_pend_d = 1'b0;
            tx_take_s   = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[5:0], 2'b00};
          end
        end else begin
          cnt_d = cnt_q;
        end
        // A byte completing in the same cycle as SS rise leaves the counter at zero.
        if (ss_rise_s) begin
          state_d       = IDLE;
          frame_end_d   = 1'b1;
          err_partial_d = (cnt_d != 2'd0);
        end else begin
          state_d = ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tx_take_s) begin
      if (!tx_ready_q) begin
        tx_shift_d = hold_q;
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d = 8'h00;
        underrun_d = 1'b1;
      end
    end else begin
      tx_shift_d = tx_shift_d;
    end

    if (TX_LOAD && tx_ready_q) begin
      hold_d     = TX_DATA;
      tx_ready_d = 1'b0;
    end else begin
      hold_d = hold_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q         <= 2'd0;
      rx_shift_q    <= 6'd0;
      rx_data_q     <= 8'h00;
      rxb_done_q    <= 1'b0;
      rxb_first_q   <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_first_q    <= 1'b0;
      first_byte_q  <= 1'b0;
      tx_shift_q    <= 8'h00;
      hold_q        <= 8'h00;
      tx_ready_q    <= 1'b1;
      underrun_q    <= 1'b0;
      load_pend_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      err_partial_q <= 1'b0;
      qd_write_q    <= 2'b00;
      qd_oe_q       <= 2'b00;
    end else begin
      cnt_q         <= cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rxb_done_q    <= rxb_done_d;
      rxb_first_q   <= rxb_first_d;
      rx_valid_q    <= rx_valid_d;
      rx_first_q    <= rx_first_d;
      first_byte_q  <= first_byte_d;
      tx_shift_q    <= tx_shift_d;
      hold_q        <= hold_d;
      tx_ready_q    <= tx_ready_d;
      underrun_q    <= underrun_d;
      load_pend_q   <= load_pend_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      err_partial_q <= err_partial_d;
      qd_write_q    <= qd_write_d;
      qd_oe_q       <= qd_oe_d;
    end
  end

  assign QD_WRITE        = qd_write_q;
  assign QD_WRITE_ENABLE = qd_oe_q;
  assign RX_DATA         = rx_data_q;
  assign RX_VALID        = rx_valid_q;
  assign RX_FIRST        = rx_first_q;
  assign TX_READY        = tx_ready_q;
  assign TX_UNDERRUN     = underrun_q;
  assign BUSY            = (state_q == ACTIVE);
  assign FRAME_START     = frame_start_q;
  assign FRAME_END       = frame_end_q;
  assign ERR_PARTIAL     = err_partial_q;
endmodule

// File: tb/tb_qspi_dual_phy.sv
// Bench for qspi_dual_phy: acts as the MCU on the pins, predicts strobes from bit/byte
// counts with pin-to-output latencies, and checks TX pairs where the MCU samples them.
module tb_qspi_dual_phy;
  localparam int N    = 2;     // synchronizer depth
  localparam int H    = 6;     // SCLK half period and SS setup, in CLK cycles
  localparam int MAXC = 8192;

  logic       CLK = 1'b0;
  logic       RST_N, SS, SCLK, TX_LOAD, TX_EN;
  logic [1:0] QD_READ, QD_WRITE, QD_WRITE_ENABLE;
  logic [7:0] RX_DATA, TX_DATA;
  logic       RX_VALID, RX_FIRST, TX_READY, TX_UNDERRUN, BUSY;
  logic       FRAME_START, FRAME_END, ERR_PARTIAL;

  qspi_dual_phy #(.SYNC_STAGES(N)) dut (
    .CLK(CLK), .RST_N(RST_N), .SS(SS), .SCLK(SCLK), .QD_READ(QD_READ),
    .QD_WRITE(QD_WRITE), .QD_WRITE_ENABLE(QD_WRITE_ENABLE),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_FIRST(RX_FIRST),
    .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD), .TX_READY(TX_READY), .TX_EN(TX_EN),
    .TX_UNDERRUN(TX_UNDERRUN), .BUSY(BUSY), .FRAME_START(FRAME_START),
    .FRAME_END(FRAME_END), .ERR_PARTIAL(ERR_PARTIAL)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Expected strobes per cycle index; e_busy: 1 = BUSY rises, 2 = BUSY falls.
  bit         e_fs[MAXC], e_fe[MAXC], e_ep[MAXC], e_rxv[MAXC], e_rxf[MAXC];
  logic [7:0] e_rxd[MAXC];
  int         e_busy[MAXC];

  bit         m_active = 1'b0;
  bit         m_busy = 1'b0;
  int         m_bits = 0;
  int         m_bytes = 0;
  logic [7:0] m_acc = 8'h00;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(posedge CLK) begin
    #3;
    if (cyc < MAXC) begin
      if (e_busy[cyc] == 1) m_busy = 1'b1;
      else if (e_busy[cyc] == 2) m_busy = 1'b0;
      chk("FRAME_START", {7'd0, FRAME_START}, {7'd0, e_fs[cyc]});
      chk("FRAME_END",   {7'd0, FRAME_END},   {7'd0, e_fe[cyc]});
      chk("ERR_PARTIAL", {7'd0, ERR_PARTIAL}, {7'd0, e_ep[cyc]});
      chk("RX_VALID",    {7'd0, RX_VALID},    {7'd0, e_rxv[cyc]});
      chk("RX_FIRST",    {7'd0, RX_FIRST},    {7'd0, e_rxf[cyc]});
      chk("BUSY",        {7'd0, BUSY},        {7'd0, m_busy});
      if (e_rxv[cyc]) chk("RX_DATA", RX_DATA, e_rxd[cyc]);
    end
  end

  task automatic model_end(input int c);
    e_fe[c+N+1]   = 1'b1;
    e_ep[c+N+1]   = (m_bits % 4 != 0);
    e_busy[c+N+1] = 2;
    m_active      = 1'b0;
  endtask

  task automatic model_rise(input logic [1:0] p, input bit end_frame);
    int c = cyc;
    if (m_active) begin
      m_acc = {m_acc[5:0], p};
      m_bits++;
      if (m_bits % 4 == 0) begin
        e_rxv[c+N+2] = 1'b1;
        e_rxd[c+N+2] = m_acc;
        e_rxf[c+N+2] = (m_bytes == 0);
        m_bytes++;
      end
      if (end_frame) model_end(c);
    end
  endtask

  task automatic ss_fall();
    @(negedge CLK);
    SS = 1'b0;
    m_active = 1'b1; m_bits = 0; m_bytes = 0; m_acc = 8'h00;
    e_fs[cyc+N+1]   = 1'b1;
    e_busy[cyc+N+1] = 1;
    repeat (H) @(negedge CLK);
  endtask

  task automatic ss_rise();
    @(negedge CLK);
    SS = 1'b1;
    if (m_active) model_end(cyc);
    repeat (H) @(negedge CLK);
  endtask

  // One SCLK period: low phase with QD set up, MCU samples QD_WRITE, then high phase.
  task automatic sclk_bit(input logic [1:0] rxp, input logic [1:0] txp, input bit chk_tx,
                          input bit end_frame);
    @(negedge CLK);
    QD_READ = rxp;
    repeat (H-1) @(negedge CLK);
    if (chk_tx) chk("QD_WRITE", {6'd0, QD_WRITE}, {6'd0, txp});
    SCLK = 1'b1;
    if (end_frame) SS = 1'b1;
    model_rise(rxp, end_frame);
    repeat (H) @(negedge CLK);
    SCLK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] rxb, input logic [7:0] txb, input bit chk_tx,
                           input bit end_last);
    for (int i = 0; i < 4; i++)
      sclk_bit(rxb[7-2*i -: 2], txb[7-2*i -: 2], chk_tx, end_last && (i == 3));
    repeat (H) @(negedge CLK);
  endtask

  task automatic tx_load(input logic [7:0] d);
    @(negedge CLK);
    TX_DATA = d;
    TX_LOAD = 1'b1;
    @(negedge CLK);
    TX_LOAD = 1'b0;
  endtask

  task automatic reset_checks();
    chk("rst RX_DATA", RX_DATA, 8'h00);
    chk("rst RX_VALID", {7'd0, RX_VALID}, 8'h00);
    chk("rst RX_FIRST", {7'd0, RX_FIRST}, 8'h00);
    chk("rst QD_WRITE", {6'd0, QD_WRITE}, 8'h00);
    chk("rst QD_WRITE_ENABLE", {6'd0, QD_WRITE_ENABLE}, 8'h00);
    chk("rst TX_READY", {7'd0, TX_READY}, 8'h01);
    chk("rst TX_UNDERRUN", {7'd0, TX_UNDERRUN}, 8'h00);
    chk("rst BUSY", {7'd0, BUSY}, 8'h00);
    chk("rst FRAME_START", {7'd0, FRAME_START}, 8'h00);
    chk("rst FRAME_END", {7'd0, FRAME_END}, 8'h00);
    chk("rst ERR_PARTIAL", {7'd0, ERR_PARTIAL}, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    for (int i = cyc + 1; i < MAXC; i++) begin
      e_fs[i] = 1'b0; e_fe[i] = 1'b0; e_ep[i] = 1'b0;
      e_rxv[i] = 1'b0; e_rxf[i] = 1'b0; e_busy[i] = 0;
    end
    e_busy[cyc+1] = 2;
    m_active = 1'b0;
    repeat (5) @(negedge CLK);
    reset_checks();
    RST_N = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0; SS = 1'b1; SCLK = 1'b0; QD_READ = 2'b00;
    TX_DATA = 8'h00; TX_LOAD = 1'b0; TX_EN = 1'b0;
    repeat (5) @(negedge CLK);
    reset_checks();
    RST_N = 1'b1;
    repeat (6) @(negedge CLK);

    // RX 0xB1 then 0x5A; TX 0xC3 from holding, then an underrun filler byte.
    tx_load(8'hC3);
    chk("TX_READY after load", {7'd0, TX_READY}, 8'h00);
    TX_EN = 1'b1;
    ss_fall();
    chk("TX_READY after frame load", {7'd0, TX_READY}, 8'h01);
    chk("TX_UNDERRUN at start", {7'd0, TX_UNDERRUN}, 8'h00);
    chk("QD_WRITE_ENABLE on", {6'd0, QD_WRITE_ENABLE}, 8'h03);
    send_byte(8'hB1, 8'hC3, 1'b1, 1'b0);
    chk("RX_DATA B1", RX_DATA, 8'hB1);
    chk("TX_UNDERRUN set", {7'd0, TX_UNDERRUN}, 8'h01);
    send_byte(8'h5A, 8'h00, 1'b1, 1'b0);
    chk("RX_DATA 5A", RX_DATA, 8'h5A);
    ss_rise();
    chk("QD_WRITE_ENABLE off", {6'd0, QD_WRITE_ENABLE}, 8'h00);
    chk("TX_UNDERRUN sticky", {7'd0, TX_UNDERRUN}, 8'h01);

    // Two loaded TX bytes; a load while not ready must be ignored.
    tx_load(8'hA5);
    ss_fall();
    chk("TX_UNDERRUN cleared", {7'd0, TX_UNDERRUN}, 8'h00);
    tx_load(8'h3C);
    chk("TX_READY full", {7'd0, TX_READY}, 8'h00);
    tx_load(8'hFF);
    send_byte(8'h12, 8'hA5, 1'b1, 1'b0);
    chk("TX_READY reload", {7'd0, TX_READY}, 8'h01);
    chk("TX_UNDERRUN none", {7'd0, TX_UNDERRUN}, 8'h00);
    send_byte(8'hFE, 8'h3C, 1'b1, 1'b0);
    chk("TX_UNDERRUN end", {7'd0, TX_UNDERRUN}, 8'h01);
    ss_rise();

    // Partial frame: two pairs then SS rise.
    TX_EN = 1'b0;
    ss_fall();
    chk("QD_WRITE_ENABLE tx_en0", {6'd0, QD_WRITE_ENABLE}, 8'h00);
    chk("TX_UNDERRUN empty start", {7'd0, TX_UNDERRUN}, 8'h01);
    sclk_bit(2'b01, 2'b00, 1'b0, 1'b0);
    sclk_bit(2'b10, 2'b00, 1'b0, 1'b0);
    repeat (H) @(negedge CLK);
    ss_rise();
    chk("RX_DATA kept after partial", RX_DATA, 8'hFE);

    // Fourth rise and SS rise land in the same synchronized cycle.
    ss_fall();
    send_byte(8'hE4, 8'h00, 1'b0, 1'b1);
    chk("RX_DATA E4", RX_DATA, 8'hE4);
    chk("BUSY after boundary", {7'd0, BUSY}, 8'h00);

    // SCLK toggling with SS high is ignored.
    send_byte(8'hFF, 8'h00, 1'b0, 1'b0);
    chk("RX_DATA idle sclk", RX_DATA, 8'hE4);

    // Reset mid-frame, then a clean frame.
    tx_load(8'h77);
    ss_fall();
    sclk_bit(2'b11, 2'b00, 1'b0, 1'b0);
    sclk_bit(2'b11, 2'b00, 1'b0, 1'b0);
    repeat (H) @(negedge CLK);
    do_reset();
    repeat (H) @(negedge CLK);
    chk("BUSY after reset", {7'd0, BUSY}, 8'h00);
    ss_rise();
    ss_fall();
    chk("TX_UNDERRUN after reset", {7'd0, TX_UNDERRUN}, 8'h01);
    send_byte(8'h81, 8'h00, 1'b0, 1'b0);
    chk("RX_DATA 81", RX_DATA, 8'h81);
    ss_rise();

    repeat (10) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/qspi_dual_phy.md
# qspi_dual_phy

Clock-domain front end between the dual-line QSPI pins and the memory/command logic. Synchronizes SS, SCLK and QD into CLK, deserializes received 2-bit pairs into bytes with a valid strobe, and serializes transmit bytes back onto QD under a ready/load handshake. Sits directly between the SB_IO tristate pads (QD_READ / QD_WRITE / QD_WRITE_ENABLE) and the QSPI memory block, so downstream logic only handles byte-wide, CLK-synchronous traffic.

## Interface
- SYNC_STAGES, 2, synchronizer depth for SS/SCLK/QD_READ (>=2)
- CLK  in  1  system clock (80 MHz PLL output)
- RST_N  in  1  asynchronous, active-low reset
- SS  in  1  chip select from MCU, active low, asynchronous
- SCLK  in  1  QSPI clock from MCU, asynchronous
- QD_READ  in  2  pad input data (SB_IO D_IN_0)
- QD_WRITE  out  2  pad output data (SB_IO D_OUT_0)
- QD_WRITE_ENABLE  out  2  pad output enables, both bits always equal
- RX_DATA  out  8  last received byte, held until the next byte
- RX_VALID  out  1  one-cycle strobe, RX_DATA new; no backpressure
- RX_FIRST  out  1  qualifies RX_VALID: first byte of the frame
- TX_DATA  in  8  byte to transmit
- TX_LOAD  in  1  TX_DATA accepted when TX_LOAD & TX_READY
- TX_READY  out  1  holding register empty
- TX_EN  in  1  1 = drive QD while frame active
- TX_UNDERRUN  out  1  sticky per frame: a 0x00 filler byte was shifted out
- BUSY  out  1  synchronized frame-active (SS low)
- FRAME_START  out  1  one-cycle pulse on synchronized SS fall
- FRAME_END  out  1  one-cycle pulse on synchronized SS rise
- ERR_PARTIAL  out  1  one-cycle pulse with FRAME_END if frame ended mid-byte

## Operation
- SS, SCLK, QD_READ pass through identical SYNC_STAGES flop chains (QD stays aligned to SCLK). One extra register per SS/SCLK forms edge detectors.
- States: IDLE (SS high), ACTIVE (SS low). IDLE->ACTIVE on sync SS fall: pulse FRAME_START, clear pair counter, clear TX_UNDERRUN, load TX shift register. ACTIVE->IDLE on sync SS rise: pulse FRAME_END, drop enables.
- SCLK edges ignored in IDLE.
- RX: each sync SCLK rise in ACTIVE shifts in {QD[1],QD[0]}; first pair = bits [7:6], MSB first. 2-bit pair counter; on 4th rise RX_DATA updates and RX_VALID pulses next cycle; counter wraps to 0. RX_FIRST high with the first RX_VALID of each frame only.
- TX shift register loads at FRAME_START and on the falling edge after each 4th rise: from holding register if full (TX_READY then returns 1 next cycle), else 0x00 and TX_UNDERRUN set.
- QD_WRITE = shift[7:6] after load; shift left 2 on every sync SCLK fall other than a load fall.
- QD_WRITE_ENABLE = {2{TX_EN & BUSY}}, registered. TX_EN sampled live.
- Holding register: TX_LOAD & TX_READY captures TX_DATA, TX_READY=0 next cycle. TX_LOAD with TX_READY=0 ignored. Holding register persists across frames.
- Simultaneous 4th rise and SS rise in same sync cycle: byte completes, RX_VALID pulses, FRAME_END pulses, no ERR_PARTIAL.
- SS rise with counter 1..3: partial bits discarded, ERR_PARTIAL with FRAME_END.
- RST_N low at any time (including mid-frame): all state cleared immediately; return to IDLE.

## Timing
- Reset values: RX_DATA=0x00, RX_VALID=0, RX_FIRST=0, QD_WRITE=2'b00, QD_WRITE_ENABLE=2'b00, TX_READY=1, TX_UNDERRUN=0, BUSY=0, FRAME_START=0, FRAME_END=0, ERR_PARTIAL=0; holding and shift registers 0x00.
- Pin-to-detect latency: SYNC_STAGES+1 CLK. RX_VALID asserts SYNC_STAGES+2 CLK after the 4th SCLK rise at the pin.
- QD_WRITE updates SYNC_STAGES+2 CLK after SCLK fall at the pin. MCU samples on the next rise.
- SCLK high and low phases each >= SYNC_STAGES+2 CLK periods (80 MHz, depth 2: SCLK <= 10 MHz).
- SS setup to first SCLK rise >= SYNC_STAGES+2 CLK.

## Test plan
- Reset: RST_N low 5 cycles mid-frame -> all outputs at reset values, BUSY=0, next frame starts clean.
- RX: SS low, pairs 2'b10,2'b11,2'b00,2'b01 -> RX_DATA=0xB1, RX_VALID one cycle, RX_FIRST=1. Second byte 0x5A -> RX_FIRST=0.
- TX: TX_LOAD 0xC3 before frame, TX_EN=1 -> QD_WRITE 11,00,00,11 across 4 SCLK cycles. TX_READY returns 1 at reload.
- Underrun: TX_EN=1, no TX_LOAD for second byte -> 0x00 shifted, TX_UNDERRUN=1 until next FRAME_START.
- Partial: SS rises after 2 SCLK rises -> FRAME_END and ERR_PARTIAL same cycle, no RX_VALID.
- Boundary: 4th rise and SS rise synchronized together -> RX_VALID and FRAME_END, ERR_PARTIAL=0. SCLK toggles with SS high -> no RX_VALID.
